note_recorder: RTL and testbench
================================

# note_recorder

Captures a note sequence entered by a player on the four note keys and packs it into the `level_data`/`level_length` format that the playback and response blocks consume: four bits per note, one-hot, first note in the MSBs. It is the writer side of the level interface and enables a two-player "compose then repeat" mode. It sits beside `game_core`, between the synchronized key inputs and the level register.

## Interface
- `MAX_NOTES`, default 4: note capacity. Legal range 1–15.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed to accept a press. Must be ≥1.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: single-cycle pulse that clears the buffer and begins recording.
- `finish` input, 1 bit: single-cycle pulse that ends recording early.
- `note_inputs` input, 4 bits: raw key levels, active-high, asynchronous to `clk`.
- `level_data` output, 4*MAX_NOTES bits: packed notes. Slot i is `[4*(MAX_NOTES-1-i) +: 4]`.
- `level_length` output, 4 bits: number of notes stored.
- `busy` output, 1 bit: high while recording.
- `level_valid` output, 1 bit: high in DONE when `level_length` > 0.
- `note_accepted` output, 1 bit: one-cycle pulse for each note stored.
- `chord_error` output, 1 bit: sticky flag for a rejected multi-key press. Cleared by `start`.

## Operation
- A 2-flop synchronizer feeds `note_inputs` into `sync` (reset 0). All decisions below use `sync`.
- States: IDLE, ARMED, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, DONE.
- IDLE: `busy`=0.
  - `start` clears `level_data`, `level_length`, `level_valid` and `chord_error`, then goes to ARMED.
- ARMED (`busy`=1): waits for `sync`==0 so a key held at `start` is not recorded, then goes to WAIT_PRESS.
- WAIT_PRESS:
  - `finish` → DONE.
  - `sync`≠0: latch `candidate`=`sync`, set `cnt`=1, go to DEBOUNCE.
- DEBOUNCE:
  - `sync`==0: discard the candidate and return to WAIT_PRESS.
  - `sync`≠0 but ≠`candidate`: set `candidate`=`sync`, `cnt`=1.
  - Otherwise `cnt` increments. When `cnt` reaches DEBOUNCE_CYCLES the press is accepted:
    - Candidate one-hot: write it to slot `level_length`, increment `level_length`, pulse `note_accepted`.
    - Candidate not one-hot: set `chord_error`, store nothing.
    - Either way, go to WAIT_RELEASE.
  - `finish` → DONE and the candidate is discarded.
- WAIT_RELEASE:
  - `finish` → DONE.
  - On `sync`==0: go to DONE if `level_length`==MAX_NOTES, else to WAIT_PRESS.
- DONE: `busy`=0. `level_valid` = (`level_length`≠0). `level_data` is held stable. `start` restarts recording exactly as from IDLE.
- Priority, highest first: `reset`, `start` (in any state, including mid-recording), `finish`, key activity.
- Unwritten slots are always 0.
- `level_length` saturates at MAX_NOTES. It can never exceed it because a full buffer forces DONE.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0; `level_data` all zeros.
  - `sync`, `candidate` and `cnt` are 0.
- All outputs are registered. `note_accepted`, the slot write and the `level_length` increment take effect on the same edge.
- Latency: a raw press stable from before edge k is first seen in `sync` at edge k+2. The note is accepted at edge k+1+DEBOUNCE_CYCLES. `note_accepted` is high for the following cycle.
- A glitch shorter than DEBOUNCE_CYCLES samples produces no write and no flag.
- Exactly one note is recorded per press/release pair, regardless of hold duration.
- `start` and `finish` asserted in the same cycle: `start` wins.
- `finish` in IDLE or DONE is ignored.
- `reset` asserted mid-recording returns the block to reset values immediately.

## Configuration
- `NOTE_RECORDER_DEBOUNCE_EN` defined: DEBOUNCE state and `cnt` are present, and behaviour is as above.
- Undefined: DEBOUNCE is compiled out and DEBOUNCE_CYCLES is ignored. WAIT_PRESS accepts `sync` on the first edge it is nonzero, with the same one-hot/chord rule, and goes straight to WAIT_RELEASE. Latency becomes edge k+2.

## Test plan
- MAX_NOTES=4, DEBOUNCE_CYCLES=4, macro on. Pulse `start`, then press/release 0001, 0010, 0100, 1000, each held 10 cycles → `level_data`=16'h1248, `level_length`=4, `level_valid`=1, four `note_accepted` pulses, `busy`=0.
- Glitch: 0100 held 2 cycles, then a 0010 press held 10 cycles → only 0010 is stored; `level_data`=16'h2000, `level_length`=1 after `finish`.
- Chord: press 0011 for 10 cycles, then 1000 → `chord_error`=1, `level_data`=16'h8000, `level_length`=1. A following `start` clears `chord_error` to 0.
- Early finish: notes 0001 and 1000, then `finish` → DONE, `level_data`=16'h1800, `level_length`=2, `level_valid`=1. `finish` with no notes → `level_valid`=0.
- Key held across `start`: 0100 held before and after `start` → nothing recorded until release and a re-press.
- Reset mid-recording after one note → all outputs 0 on the next sample. A fresh recording then works normally. Repeat the first scenario with the macro undefined → each note accepted at edge k+2.

Source files
------------

// File: rtl/note_recorder.sv
// Note sequence recorder: captures one-hot key presses into the packed level_data/level_length format.
// Optional debounce filtering is compiled in with `define NOTE_RECORDER_DEBOUNCE_EN.
module note_recorder #(
    parameter int MAX_NOTES       = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   finish,
    input  logic [3:0]             note_inputs,
    output logic [4*MAX_NOTES-1:0] level_data,
    output logic [3:0]             level_length,
    output logic                   busy,
    output logic                   level_valid,
    output logic                   note_accepted,
    output logic                   chord_error
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_ARMED        = 3'd1;
    localparam logic [2:0] S_WAIT_PRESS   = 3'd2;
`ifdef NOTE_RECORDER_DEBOUNCE_EN
    localparam logic [2:0] S_DEBOUNCE     = 3'd3;
`endif
    localparam logic [2:0] S_WAIT_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE         = 3'd5;

    localparam logic [3:0] MAX_LEN = 4'(MAX_NOTES);

    logic [3:0]             sync1_q, sync_q;
    logic [2:0]             state_q, state_d;
    logic [4*MAX_NOTES-1:0] data_q, data_d;
    logic [3:0]             len_q, len_d;
    logic                   valid_q, valid_d;
    logic                   acc_q, acc_d;
    logic                   chord_q, chord_d;
    logic                   busy_q, busy_d;
    logic                   accept;
    logic [3:0]             accept_val;
    int                     slot_lo;

`ifdef NOTE_RECORDER_DEBOUNCE_EN
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CW-1:0]  DC_L = CW'(DEBOUNCE_CYCLES);
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = cnt_q + CW'(1);
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        len_d      = len_q;
        acc_d      = 1'b0;
        chord_d    = chord_q;
        accept     = 1'b0;
        accept_val = sync_q;
        slot_lo    = 4 * (MAX_NOTES - 1 - int'(len_q));
`ifdef NOTE_RECORDER_DEBOUNCE_EN
        cand_d     = cand_q;
        cnt_d      = cnt_q;
`endif
        // start overrides everything, in every state
        if (start) begin
            state_d = S_ARMED;
            data_d  = '0;
            len_d   = 4'd0;
            chord_d = 1'b0;
`ifdef NOTE_RECORDER_DEBOUNCE_EN
            cand_d  = 4'd0;
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (sync_q == 4'd0) state_d = S_WAIT_PRESS;
                end
                S_WAIT_PRESS: begin
                    if (finish) begin
                        state_d = S_DONE;
                    end else if (sync_q != 4'd0) begin
`ifdef NOTE_RECORDER_DEBOUNCE_EN
                        cand_d  = sync_q;
                        cnt_d   = CW'(1);
                        state_d = S_DEBOUNCE;
`else
                        accept  = 1'b1;
                        state_d = S_WAIT_RELEASE;
`endif
                    end
                end
`ifdef NOTE_RECORDER_DEBOUNCE_EN
                S_DEBOUNCE: begin
                    if (finish) begin
                        state_d = S_DONE;
                        cand_d  = 4'd0;
                        cnt_d   = '0;
                    end else if (sync_q == 4'd0) begin
                        state_d = S_WAIT_PRESS;
                        cand_d  = 4'd0;
                        cnt_d   = '0;
                    end else if (sync_q != cand_q) begin
                        cand_d = sync_q;
                        cnt_d  = CW'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DC_L) begin
                            accept     = 1'b1;
                            accept_val = cand_q;
                            state_d    = S_WAIT_RELEASE;
                        end
                    end
                end
`endif
                S_WAIT_RELEASE: begin
                    if (finish) begin
                        state_d = S_DONE;
                    end else if (sync_q == 4'd0) begin
                        state_d = (len_q == MAX_LEN) ? S_DONE : S_WAIT_PRESS;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            if ($onehot(accept_val)) begin
                if (len_q < MAX_LEN) begin
                    data_d[slot_lo +: 4] = accept_val;
                    len_d                = len_q + 4'd1;
                    acc_d                = 1'b1;
                end
            end else begin
                chord_d = 1'b1;
            end
        end

        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        valid_d = (state_d == S_DONE) && (len_d != 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'd0;
            sync_q  <= 4'd0;
            state_q <= S_IDLE;
            data_q  <= '0;
            len_q   <= 4'd0;
            valid_q <= 1'b0;
            acc_q   <= 1'b0;
            chord_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef NOTE_RECORDER_DEBOUNCE_EN
            cand_q  <= 4'd0;
            cnt_q   <= '0;
`endif
        end else begin
            sync1_q <= note_inputs;
            sync_q  <= sync1_q;
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            chord_q <= chord_d;
            busy_q  <= busy_d;
`ifdef NOTE_RECORDER_DEBOUNCE_EN
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign level_data    = data_q;
    assign level_length  = len_q;
    assign busy          = busy_q;
    assign level_valid   = valid_q;
    assign note_accepted = acc_q;
    assign chord_error   = chord_q;

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder: directed scenarios plus randomized press sequences
// compared against a press-level model (a press counts if held at least the debounce length).
module tb_note_recorder;
    localparam int MAX = 4;
    localparam int DC  = 4;
`ifdef NOTE_RECORDER_DEBOUNCE_EN
    localparam int DC_EFF = DC;
`else
    localparam int DC_EFF = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             finish = 1'b0;
    logic [3:0]       note_inputs = 4'd0;
    logic [4*MAX-1:0] level_data;
    logic [3:0]       level_length;
    logic             busy, level_valid, note_accepted, chord_error;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;
    int pv[16];
    int ph[16];

    note_recorder #(.MAX_NOTES(MAX), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .note_inputs(note_inputs), .level_data(level_data),
        .level_length(level_length), .busy(busy), .level_valid(level_valid),
        .note_accepted(note_accepted), .chord_error(chord_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (note_accepted) pulses <= pulses + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0; tick();
    endtask

    task automatic pulse_finish();
        finish = 1'b1; tick(); finish = 1'b0; tick();
    endtask

    task automatic press(input logic [3:0] v, input int h);
        note_inputs = v;
        repeat (h) tick();
        note_inputs = 4'd0;
        repeat (4) tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_data"},  level_data, 0);
        chk({tag, "_len"},   level_length, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_valid"}, level_valid, 0);
        chk({tag, "_acc"},   note_accepted, 0);
        chk({tag, "_chord"}, chord_error, 0);
    endtask

    // Model: walk the presses; a press held >= DC_EFF samples is a note (one-hot) or a chord
    // error; nothing is taken once MAX notes are stored.
    task automatic run_seq(input string tag, input int n);
        logic [63:0] exp_data = 0;
        logic [63:0] nib;
        int  len = 0;
        bit  chord = 0;
        int  base;
        pulse_start();
        base = pulses;
        for (int i = 0; i < n; i++) begin
            if (len < MAX && ph[i] >= DC_EFF) begin
                if ($onehot(pv[i][3:0])) begin
                    nib = 64'(pv[i][3:0]);
                    exp_data = exp_data | (nib << (4 * (MAX - 1 - len)));
                    len++;
                end else begin
                    chord = 1;
                end
            end
            press(pv[i][3:0], ph[i]);
        end
        pulse_finish();
        chk({tag, "_data"},   level_data, exp_data);
        chk({tag, "_len"},    level_length, len);
        chk({tag, "_valid"},  level_valid, len != 0);
        chk({tag, "_chord"},  chord_error, chord);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_pulses"}, pulses - base, len);
    endtask

    initial begin
        int base;
        int first;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        pulse_finish();
        check_idle_outputs("finish_in_idle");

        pv[0] = 1; pv[1] = 2; pv[2] = 4; pv[3] = 8;
        for (int i = 0; i < 4; i++) ph[i] = 10;
        run_seq("four_notes", 4);
        chk("four_notes_literal", level_data, 16'h1248);

        pv[0] = 4; ph[0] = 2; pv[1] = 2; ph[1] = 10;
        run_seq("glitch", 2);

        pv[0] = 3; ph[0] = 10; pv[1] = 8; ph[1] = 10;
        run_seq("chord", 2);
        chk("chord_literal", level_data, 16'h8000);
        pulse_start();
        chk("chord_cleared", chord_error, 0);
        chk("restart_busy", busy, 1);
        chk("restart_len", level_length, 0);

        pv[0] = 1; ph[0] = 10; pv[1] = 8; ph[1] = 10;
        run_seq("early_finish", 2);
        chk("early_finish_literal", level_data, 16'h1800);
        run_seq("empty_finish", 0);

        // key held across start must not be recorded until released and pressed again
        note_inputs = 4'b0100;
        repeat (5) tick();
        pulse_start();
        base = pulses;
        repeat (10) tick();
        note_inputs = 4'd0;
        repeat (4) tick();
        chk("held_start_pulses", pulses - base, 0);
        chk("held_start_len", level_length, 0);
        chk("held_start_busy", busy, 1);
        press(4'b0100, 10);
        pulse_finish();
        chk("held_repress_len", level_length, 1);
        chk("held_repress_data", level_data, 16'h4000);

        pulse_start();
        press(4'b0010, 10);
        chk("pre_reset_len", level_length, 1);
        reset = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        tick();
        pv[0] = 8; pv[1] = 4; pv[2] = 2; pv[3] = 1;
        for (int i = 0; i < 4; i++) ph[i] = 10;
        run_seq("after_reset", 4);

        // latency: raw set before edge k, note_accepted first visible after edge k+1+DC_EFF
        pulse_start();
        note_inputs = 4'b0010;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (note_accepted && first == 0) first = n;
        end
        note_inputs = 4'd0;
        repeat (4) tick();
        chk("latency", first, 2 + DC_EFF);
        pulse_finish();

        for (int it = 0; it < 25; it++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom % 3 != 0) pv[i] = 1 << $urandom_range(0, 3);
                else                   pv[i] = $urandom_range(1, 15);
                if ($urandom % 4 == 0) ph[i] = $urandom_range(1, 3);
                else                   ph[i] = $urandom_range(4, 12);
            end
            run_seq($sformatf("rand%0d", it), n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
